// File: rtl/axis_s_pkt_rx_if.sv
// AXI-Stream beat channel shared by axis_s_pkt_rx and its upstream source.
//   tvalid : source has a beat on tdata/tlast
//   tdata  : beat payload, DATA_W bits
//   tlast  : marks the final beat of a packet
//   tready : sink can accept a beat this cycle
// Modports: master drives the beat, slave returns tready.
interface axis_s_pkt_rx_if #(
  parameter int DATA_W = 8
);
  logic              tvalid;
  logic [DATA_W-1:0] tdata;
  logic              tlast;
  logic              tready;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/axis_s_pkt_rx.sv
// AXI-Stream slave receiving fixed PKT_LEN-beat packets and checking tlast framing.
// Good packets are assembled into pkt_data and held on a valid/ready handshake;
// short packets (early tlast) and long packets (no tlast on the final beat) are
// discarded, pulsed on err_short/err_long and counted in err_count.
// Ports:
//   s_axis_aclk    : clock, rising edge
//   s_axis_aresetn : asynchronous active-low reset
//   s_axis         : beat channel (slave modport), tready is registered
//   pkt_valid/pkt_ready/pkt_data : assembled packet handshake, beat 0 in the LSBs
//   pkt_count      : good packets accepted, wraps
//   err_short/err_long : one-cycle error pulses
//   err_count      : short plus long errors, wraps
module axis_s_pkt_rx #(
  parameter int DATA_W  = 8,
  parameter int PKT_LEN = 4,
  parameter int CNT_W   = 16
) (
  input  logic                      s_axis_aclk,
  input  logic                      s_axis_aresetn,
  axis_s_pkt_rx_if.slave            s_axis,
  output logic                      pkt_valid,
  input  logic                      pkt_ready,
  output logic [PKT_LEN*DATA_W-1:0] pkt_data,
  output logic [CNT_W-1:0]          pkt_count,
  output logic                      err_short,
  output logic                      err_long,
  output logic [CNT_W-1:0]          err_count
);

  localparam int          IDX_W    = $clog2(PKT_LEN);
  localparam int unsigned BUF_N    = PKT_LEN - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PKT_LEN - 1);

  typedef enum logic [1:0] {
    ST_RECV = 2'd0,
    ST_DROP = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [IDX_W-1:0]            r_idx;
  logic [IDX_W-1:0]            w_idx_nxt;
  logic                        r_tready;
  logic                        w_xfer;
  logic                        w_good;
  logic                        w_short;
  logic                        w_long;
  logic                        r_err_short;
  logic                        r_err_long;
  logic [DATA_W-1:0]           r_buf [BUF_N];
  logic [PKT_LEN*DATA_W-1:0]   w_asm;
  logic [PKT_LEN*DATA_W-1:0]   r_pkt_data;
  logic [CNT_W-1:0]            r_pkt_count;
  logic [CNT_W-1:0]            r_err_count;

  assign w_xfer = s_axis.tvalid & r_tready;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_good      = 1'b0;
    w_short     = 1'b0;
    w_long      = 1'b0;
    case (r_state)
      ST_RECV: begin
        if (w_xfer) begin
          if (s_axis.tlast) begin
            w_idx_nxt = '0;
            if (r_idx == LAST_IDX) begin
              w_good      = 1'b1;
              w_state_nxt = ST_HOLD;
            end else begin
              w_short = 1'b1;
            end
          end else if (r_idx == LAST_IDX) begin
            w_long      = 1'b1;
            w_idx_nxt   = '0;
            w_state_nxt = ST_DROP;
          end else begin
            w_idx_nxt = r_idx + IDX_W'(1);
          end
        end
      end
      ST_DROP: begin
        if (w_xfer && s_axis.tlast) w_state_nxt = ST_RECV;
      end
      ST_HOLD: begin
        if (pkt_ready) w_state_nxt = ST_RECV;
      end
      default: begin
        w_state_nxt = ST_RECV;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // The final beat is never buffered: it is taken straight from tdata while
  // the rest of the packet comes out of the working buffer.
  always_comb begin
    w_asm = '0;
    for (int unsigned i = 0; i < BUF_N; i++) begin
      w_asm[i*DATA_W +: DATA_W] = r_buf[i];
    end
    w_asm[BUF_N*DATA_W +: DATA_W] = s_axis.tdata;
  end

  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      r_state     <= ST_RECV;
      r_idx       <= '0;
      r_tready    <= 1'b0;
      r_err_short <= 1'b0;
      r_err_long  <= 1'b0;
      r_pkt_data  <= '0;
      r_pkt_count <= '0;
      r_err_count <= '0;
      for (int unsigned i = 0; i < BUF_N; i++) r_buf[i] <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_idx       <= w_idx_nxt;
      // tready follows the next state so it is already low on the first HOLD cycle.
      r_tready    <= (w_state_nxt != ST_HOLD);
      r_err_short <= w_short;
      r_err_long  <= w_long;
      if (w_good) begin
        r_pkt_data  <= w_asm;
        r_pkt_count <= r_pkt_count + CNT_W'(1);
      end
      if (w_short || w_long) r_err_count <= r_err_count + CNT_W'(1);
      if (r_state == ST_RECV && w_xfer) begin
        for (int unsigned i = 0; i < BUF_N; i++) begin
          if (r_idx == IDX_W'(i)) r_buf[i] <= s_axis.tdata;
        end
      end
    end
  end

  assign s_axis.tready = r_tready;
  assign pkt_valid     = (r_state == ST_HOLD);
  assign pkt_data      = r_pkt_data;
  assign pkt_count     = r_pkt_count;
  assign err_count     = r_err_count;
  assign err_short     = r_err_short;
  assign err_long      = r_err_long;

endmodule

// File: tb/tb_axis_s_pkt_rx.sv
// Directed self-checking bench for axis_s_pkt_rx with DATA_W=8, PKT_LEN=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_axis_s_pkt_rx;

  logic        clk;
  logic        rst_n;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [31:0] pkt_data;
  logic [15:0] pkt_count;
  logic        err_short;
  logic        err_long;
  logic [15:0] err_count;

  int n_checks = 0;
  int n_errors = 0;

  axis_s_pkt_rx_if #(.DATA_W(8)) s_axis ();

  axis_s_pkt_rx #(
    .DATA_W  (8),
    .PKT_LEN (4),
    .CNT_W   (16)
  ) dut (
    .s_axis_aclk    (clk),
    .s_axis_aresetn (rst_n),
    .s_axis         (s_axis),
    .pkt_valid      (pkt_valid),
    .pkt_ready      (pkt_ready),
    .pkt_data       (pkt_data),
    .pkt_count      (pkt_count),
    .err_short      (err_short),
    .err_long       (err_long),
    .err_count      (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the transfer.
  task automatic beat(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = d;
    s_axis.tlast  = l;
    while (s_axis.tready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      n_checks++;
      n_errors++;
      $display("FAIL beat_timeout: tready stayed low, required 1");
    end
    @(posedge clk);
    @(negedge clk);
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_tready"},  s_axis.tready, 1'b0);
    chk({tag, "_valid"},   pkt_valid, 1'b0);
    chk({tag, "_data"},    pkt_data, 32'h0);
    chk({tag, "_pcount"},  pkt_count, 16'd0);
    chk({tag, "_ecount"},  err_count, 16'd0);
    chk({tag, "_eshort"},  err_short, 1'b0);
    chk({tag, "_elong"},   err_long, 1'b0);
  endtask

  logic [6:0] gap_pat;
  logic [7:0] gap_dat [4];
  int         k;
  logic [31:0] held;

  initial begin
    rst_n         = 1'b0;
    pkt_ready     = 1'b1;
    s_axis.tvalid = 1'b0;
    s_axis.tdata  = '0;
    s_axis.tlast  = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk_reset_outs("rst0");
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst0_tready_after", s_axis.tready, 1'b1);

    // Good packet, no backpressure
    beat(8'd0, 1'b0);
    beat(8'd5, 1'b0);
    beat(8'd10, 1'b0);
    beat(8'd15, 1'b1);
    chk("t1_valid",  pkt_valid, 1'b1);
    chk("t1_data",   pkt_data, 32'h0F0A0500);
    chk("t1_pcount", pkt_count, 16'd1);
    chk("t1_tready", s_axis.tready, 1'b0);
    chk("t1_eshort", err_short, 1'b0);
    @(negedge clk);
    chk("t1_tready_back", s_axis.tready, 1'b1);
    chk("t1_valid_drop",  pkt_valid, 1'b0);

    // Consumer stall for 10 cycles with upstream pushing
    pkt_ready = 1'b0;
    beat(8'd0, 1'b0);
    beat(8'd5, 1'b0);
    beat(8'd10, 1'b0);
    beat(8'd15, 1'b1);
    s_axis.tvalid = 1'b1;
    s_axis.tdata  = 8'hAA;
    s_axis.tlast  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("t2_stall_valid",  pkt_valid, 1'b1);
      chk("t2_stall_data",   pkt_data, 32'h0F0A0500);
      chk("t2_stall_tready", s_axis.tready, 1'b0);
      @(negedge clk);
    end
    chk("t2_stall_pcount", pkt_count, 16'd2);
    chk("t2_stall_ecount", err_count, 16'd0);
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    pkt_ready     = 1'b1;
    @(negedge clk);
    chk("t2_release_valid",  pkt_valid, 1'b0);
    chk("t2_release_tready", s_axis.tready, 1'b1);
    beat(8'd0, 1'b0);
    beat(8'd7, 1'b0);
    beat(8'd14, 1'b0);
    beat(8'd21, 1'b1);
    chk("t2_valid",  pkt_valid, 1'b1);
    chk("t2_data",   pkt_data, 32'h150E0700);
    chk("t2_pcount", pkt_count, 16'd3);
    @(negedge clk);

    // Short packet
    beat(8'h01, 1'b0);
    beat(8'h02, 1'b0);
    beat(8'h03, 1'b1);
    chk("t3_eshort",  err_short, 1'b1);
    chk("t3_elong",   err_long, 1'b0);
    chk("t3_ecount",  err_count, 16'd1);
    chk("t3_valid",   pkt_valid, 1'b0);
    @(negedge clk);
    chk("t3_eshort_once", err_short, 1'b0);
    beat(8'h11, 1'b0);
    beat(8'h22, 1'b0);
    beat(8'h33, 1'b0);
    beat(8'h44, 1'b1);
    chk("t3_next_valid",  pkt_valid, 1'b1);
    chk("t3_next_data",   pkt_data, 32'h44332211);
    chk("t3_next_pcount", pkt_count, 16'd4);
    @(negedge clk);

    // Long packet: 6 beats, tlast on beat 5
    beat(8'h00, 1'b0);
    beat(8'h01, 1'b0);
    beat(8'h02, 1'b0);
    chk("t4_before_elong", err_long, 1'b0);
    beat(8'h03, 1'b0);
    chk("t4_elong",  err_long, 1'b1);
    chk("t4_eshort", err_short, 1'b0);
    chk("t4_ecount", err_count, 16'd2);
    beat(8'h04, 1'b0);
    chk("t4_drop4_elong", err_long, 1'b0);
    chk("t4_drop4_valid", pkt_valid, 1'b0);
    beat(8'h05, 1'b1);
    chk("t4_drop5_elong",  err_long, 1'b0);
    chk("t4_drop5_eshort", err_short, 1'b0);
    chk("t4_drop5_valid",  pkt_valid, 1'b0);
    chk("t4_drop5_ecount", err_count, 16'd2);
    beat(8'hA0, 1'b0);
    beat(8'hB1, 1'b0);
    beat(8'hC2, 1'b0);
    beat(8'hD3, 1'b1);
    chk("t4_next_valid",  pkt_valid, 1'b1);
    chk("t4_next_data",   pkt_data, 32'hD3C2B1A0);
    chk("t4_next_pcount", pkt_count, 16'd5);
    chk("t4_next_ecount", err_count, 16'd2);
    @(negedge clk);

    // Gappy source: tvalid 1,0,0,1,0,1,1
    gap_pat    = 7'b1101001;
    gap_dat[0] = 8'h01;
    gap_dat[1] = 8'h02;
    gap_dat[2] = 8'h03;
    gap_dat[3] = 8'h04;
    k = 0;
    for (int i = 0; i < 7; i++) begin
      s_axis.tvalid = gap_pat[i];
      // idle cycles carry junk so a spurious capture would corrupt pkt_data
      s_axis.tdata  = gap_pat[i] ? gap_dat[k] : 8'hEE;
      s_axis.tlast  = (k == 3) ? 1'b1 : 1'b0;
      @(posedge clk);
      if (gap_pat[i]) k++;
      @(negedge clk);
      chk("t5_eshort", err_short, 1'b0);
      chk("t5_elong",  err_long, 1'b0);
      if (i < 6) chk("t5_valid_early", pkt_valid, 1'b0);
    end
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
    chk("t5_valid",  pkt_valid, 1'b1);
    chk("t5_data",   pkt_data, 32'h04030201);
    chk("t5_pcount", pkt_count, 16'd6);
    chk("t5_ecount", err_count, 16'd2);
    @(negedge clk);

    // Asynchronous reset mid-packet
    beat(8'h55, 1'b0);
    beat(8'h66, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("t6a");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6a_tready_after", s_axis.tready, 1'b1);
    beat(8'h10, 1'b0);
    beat(8'h20, 1'b0);
    beat(8'h30, 1'b0);
    beat(8'h40, 1'b1);
    chk("t6a_valid",  pkt_valid, 1'b1);
    chk("t6a_data",   pkt_data, 32'h40302010);
    chk("t6a_pcount", pkt_count, 16'd1);
    chk("t6a_ecount", err_count, 16'd0);
    chk("t6a_eshort", err_short, 1'b0);
    @(negedge clk);

    // Asynchronous reset during HOLD
    pkt_ready = 1'b0;
    beat(8'h01, 1'b0);
    beat(8'h02, 1'b0);
    beat(8'h03, 1'b0);
    beat(8'h04, 1'b1);
    held = pkt_data;
    chk("t6b_hold_valid", pkt_valid, 1'b1);
    chk("t6b_hold_data",  held, 32'h04030201);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outs("t6b");
    pkt_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    beat(8'h09, 1'b0);
    beat(8'h08, 1'b0);
    beat(8'h07, 1'b0);
    beat(8'h06, 1'b1);
    chk("t6b_valid",  pkt_valid, 1'b1);
    chk("t6b_data",   pkt_data, 32'h06070809);
    chk("t6b_pcount", pkt_count, 16'd1);
    chk("t6b_ecount", err_count, 16'd0);
    chk("t6b_elong",  err_long, 1'b0);
    @(negedge clk);
    chk("t6b_valid_drop", pkt_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/axis_s_pkt_rx.md
Name: axis_s_pkt_rx

Overview:
AXI-Stream slave that receives fixed-length packets of PKT_LEN beats and checks that s_axis_tlast is framed correctly on each one.
Each good packet is assembled into a parallel word and held for a downstream consumer on a valid/ready handshake.
Malformed packets are discarded, flagged with error pulses and counted.
It terminates the stream produced by the team's AXI-Stream master (4-beat packets, tlast on the final beat).

Parameters:
DATA_W, 8, width of s_axis_tdata
PKT_LEN, 4, beats per packet; legal range 2..16
CNT_W, 16, width of the good-packet and error counters

Ports:
s_axis_aclk  input  1  clock; all logic on rising edge
s_axis_aresetn  input  1  reset, asynchronous assert, active-low
s_axis_tvalid  input  1  upstream beat valid
s_axis_tdata  input  DATA_W  upstream beat data
s_axis_tlast  input  1  upstream last-beat marker
s_axis_tready  output  1  block can accept a beat
pkt_valid  output  1  assembled packet available
pkt_ready  input  1  consumer accepts the packet
pkt_data  output  PKT_LEN*DATA_W  assembled packet; beat 0 in bits [DATA_W-1:0], beat k in bits [(k+1)*DATA_W-1:k*DATA_W]
pkt_count  output  CNT_W  number of good packets accepted into HOLD; wraps modulo 2^CNT_W
err_short  output  1  one-cycle pulse: tlast arrived before beat PKT_LEN-1
err_long  output  1  one-cycle pulse: beat PKT_LEN-1 arrived without tlast
err_count  output  CNT_W  total short plus long errors; wraps

Behaviour:
- Reset (aresetn=0, asynchronous):
  - State goes to RECV; beat index idx=0.
  - Outputs: s_axis_tready=1 one cycle after reset release (held 0 while reset is asserted); pkt_valid=0; pkt_data=0; pkt_count=0; err_count=0; err_short=0; err_long=0.
  - A reset mid-packet or in HOLD discards everything; no error is flagged.
- A beat transfers only on a rising edge where s_axis_tvalid=1 and s_axis_tready=1. The block never stalls on tvalid=0; idx and state hold.
- State RECV (tready=1). On each transfer, store tdata into buffer slot idx, then:
  - tlast=1 and idx=PKT_LEN-1: good packet. Go to HOLD, idx=0, pkt_count+1.
  - tlast=1 and idx<PKT_LEN-1: short packet. Pulse err_short, err_count+1, idx=0, stay in RECV. The partial buffer is discarded.
  - tlast=0 and idx=PKT_LEN-1: long packet. Pulse err_long, err_count+1, go to DROP, idx=0.
  - Otherwise: idx+1.
- State DROP (tready=1): beats are discarded. A transfer with tlast=1 returns to RECV. There is no further error pulse, however long the packet runs.
- State HOLD (tready=0, pkt_valid=1):
  - pkt_data is stable and equals the buffer contents.
  - On pkt_ready=1: return to RECV; pkt_valid drops on the next cycle.
  - tready is asserted in the same cycle the state returns to RECV. Minimum gap between packets is therefore one bubble cycle.
- pkt_valid is asserted the cycle after the final beat is accepted. Latency from the last beat to pkt_valid is 1 cycle.
- pkt_valid is never deasserted without pkt_ready. pkt_data never changes while pkt_valid=1.
- pkt_data register updates only on entry to HOLD; the working buffer is separate from pkt_data.
- err_short and err_long are registered, high for exactly the cycle after the offending transfer, and mutually exclusive.
- Counter increments occur in that same cycle. Both counters wrap from all-ones to 0.
- Unused or illegal states recover to RECV.
- No combinational path from any input to any output.

Test Plan:
- Good packet with no backpressure: send 0,5,10,15 (DATA_W=8, PKT_LEN=4), tlast on beat 3, pkt_ready=1.
  - pkt_valid=1 one cycle after beat 3; pkt_data=0x0F0A0500; pkt_count=1.
  - tready=0 for one cycle, then 1.
- Consumer stall: same packet with pkt_ready=0 for 10 cycles.
  - pkt_valid and pkt_data stay stable; tready=0 throughout.
  - Upstream tvalid=1 causes no transfer.
  - Release pkt_ready, then send a second packet 0,7,14,21; pkt_data=0x150E0700; pkt_count=2.
- Short packet: 3 beats with tlast on beat 2.
  - err_short pulses once; err_count=1; pkt_valid stays 0.
  - A following good packet is captured correctly (idx restarted at 0).
- Long packet: 6 beats, tlast only on beat 5.
  - err_long pulses one cycle after beat 3; beats 4 and 5 are dropped.
  - Next good packet is delivered; err_count increments by exactly 1.
- Gappy source: a good packet with tvalid toggling 1,0,0,1,0,1,1.
  - Beats are stored only on handshakes; pkt_data is correct; there are no error pulses.
- Asynchronous reset mid-packet (after beat 1), and separately during HOLD:
  - Outputs clear immediately without waiting for a clock edge; counters=0.
  - After release, a fresh 4-beat packet is delivered correctly with no error flagged.
